// File: rtl/alu_multdiv.sv
`default_nettype none
// ============================================================================
// alu_multdiv : iterative 32-bit signed multiply (radix-2 Booth) and
//               restoring divide, fixed 33-cycle start-to-ready latency.
// Rev 1.0
// ============================================================================
module alu_multdiv #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [CNT_BITS-1:0] C_LAST = CNT_BITS'(WIDTH - 1);
  localparam logic [CNT_BITS-1:0] C_ONE  = CNT_BITS'(1);
  localparam logic [WIDTH-1:0]    C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [2*WIDTH:0]    acc_q, acc_d;     // {A/remainder, Q/quotient, q-1}
  logic [WIDTH-1:0]    m_q, m_d;         // multiplicand or divisor magnitude
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                dbz_q, dbz_d;
  logic                ovf_q, ovf_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                exc_q, exc_d;
  logic                rdy_q, rdy_d;

  logic             start;
  logic [WIDTH-1:0] acc_a, acc_qr;
  logic             acc_qm1;
  logic [WIDTH:0]   booth_sum, a_ext, m_ext;
  logic [WIDTH:0]   r_sh, trial;
  logic [2*WIDTH:0] booth_next, div_next;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [2*WIDTH-WIDTH:0] prod_hi;

  assign start   = ctrl_MULT ^ ctrl_DIV;
  assign acc_a   = acc_q[2*WIDTH:WIDTH+1];
  assign acc_qr  = acc_q[WIDTH:1];
  assign acc_qm1 = acc_q[0];
  assign prod_hi = acc_q[2*WIDTH:WIDTH];

  // Negation reuses the invert-plus-one path throughout.
  assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  // Booth step on a 33-bit sum so the add/sub of the most negative
  // multiplicand cannot wrap before the arithmetic shift.
  always_comb begin
    a_ext = {acc_a[WIDTH-1], acc_a};
    m_ext = {m_q[WIDTH-1], m_q};
    case ({acc_qr[0], acc_qm1})
      2'b01:   booth_sum = a_ext + m_ext;
      2'b10:   booth_sum = a_ext + ~m_ext + 1'b1;
      default: booth_sum = a_ext;
    endcase
    booth_next = {booth_sum, acc_qr};
  end

  // Restoring divide step: shift remainder/quotient left, try subtract.
  always_comb begin
    r_sh  = {acc_a, acc_qr[WIDTH-1]};
    trial = r_sh + ~{1'b0, m_q} + 1'b1;
    if (!trial[WIDTH])
      div_next = {trial[WIDTH-1:0], acc_qr[WIDTH-2:0], 1'b1, 1'b0};
    else
      div_next = {r_sh[WIDTH-1:0], acc_qr[WIDTH-2:0], 1'b0, 1'b0};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (start) begin
      cnt_d    = '0;
      is_div_d = ctrl_DIV;
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dbz_d    = (data_operandB == '0);
      ovf_d    = (data_operandA == C_MIN) && (data_operandB == '1);
      if (ctrl_MULT) begin
        state_d = S_MULT;
        m_d     = data_operandA;
        acc_d   = {{WIDTH{1'b0}}, data_operandB, 1'b0};
      end else begin
        state_d = S_DIV;
        m_d     = abs_b;
        acc_d   = {{WIDTH{1'b0}}, abs_a, 1'b0};
      end
    end else begin
      case (state_q)
        S_MULT, S_DIV: begin
          acc_d = (state_q == S_DIV) ? div_next : booth_next;
          cnt_d = cnt_q + C_ONE;
          if (cnt_q == C_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          if (!is_div_q) begin
            result_d = acc_qr;
            exc_d    = !((&prod_hi) || (~|prod_hi));
          end else if (dbz_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = neg_q ? (~acc_qr + 1'b1) : acc_qr;
            exc_d    = ovf_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire
